// File: rtl/multi_cycle_controller_pkg.sv
// multi_cycle_controller_pkg: shared types, opcode/funct constants and datapath select encodings
package multi_cycle_controller_pkg;
    typedef logic       u1;
    typedef logic [2:0] u3;
    typedef logic [5:0] u6;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BRANCHEX, ADDIEX, ADDIWB, JEX
    } state_t;
    typedef enum logic [1:0] {ALUOP_NONE, ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
    localparam u6 OP_RTYPE = 6'b000000;
    localparam u6 OP_LW    = 6'b100011;
    localparam u6 OP_SW    = 6'b101011;
    localparam u6 OP_BEQ   = 6'b000100;
    localparam u6 OP_BNE   = 6'b000101;
    localparam u6 OP_ADDI  = 6'b001000;
    localparam u6 OP_J     = 6'b000010;
    localparam u6 F_SUB    = 6'b100010;
    localparam u6 F_AND    = 6'b100100;
    localparam u6 F_OR     = 6'b100101;
    localparam u6 F_SLT    = 6'b101010;
    localparam u3 ALUC_NONE = 3'b000;
    localparam u3 ALUC_AND  = 3'b000;
    localparam u3 ALUC_OR   = 3'b001;
    localparam u3 ALUC_ADD  = 3'b010;
    localparam u3 ALUC_SUB  = 3'b110;
    localparam u3 ALUC_SLT  = 3'b111;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;
endpackage

// File: rtl/multi_cycle_controller_aludec.sv
// mc_aludec: maps the controller's aluop (and funct for R-type) onto the ALU control code
module mc_aludec
    import multi_cycle_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);
    u3 fdec;
    always_comb begin
        fdec = ALUC_ADD;
        case (funct)
            F_SUB:   fdec = ALUC_SUB;
            F_AND:   fdec = ALUC_AND;
            F_OR:    fdec = ALUC_OR;
            F_SLT:   fdec = ALUC_SLT;
            default: fdec = ALUC_ADD;
        endcase
    end
    assign alucont = aluop == ALUOP_ADD   ? ALUC_ADD :
                     aluop == ALUOP_SUB   ? ALUC_SUB :
                     aluop == ALUOP_FUNCT ? fdec     : ALUC_NONE;
endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multicycle MIPS control FSM with a handshaked unified memory
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucont,
    output logic       instr_done,
    output logic       illegal
);
    state_t state, state_nx;
    aluop_t aluop;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= FETCH;
        else state <= state_nx;

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:   state_nx = mem_ready ? DECODE : FETCH;
            DECODE:
                case (op)
                    OP_LW, OP_SW:   state_nx = MEMADR;
                    OP_RTYPE:       state_nx = RTYPEEX;
                    OP_BEQ, OP_BNE: state_nx = BRANCHEX;
                    OP_ADDI:        state_nx = ADDIEX;
                    OP_J:           state_nx = JEX;
                    default:        state_nx = FETCH;
                endcase
            MEMADR:  state_nx = op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   state_nx = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_nx = mem_ready ? FETCH : MEMWR;
            RTYPEEX: state_nx = RTYPEWB;
            ADDIEX:  state_nx = ADDIWB;
            default: state_nx = FETCH;
        endcase
    end

    // strobes are gated by resetn so an asserted reset silences the bus without a clock edge
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALU;
        pcen       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        aluop      = ALUOP_NONE;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                aluop   = ALUOP_ADD;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                aluop   = ALUOP_ADD;
                illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCHEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PC_ALUOUT;
                pcen       = op == OP_BEQ ? zero : ~zero;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcsrc      = PC_JUMP;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (!resetn) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    mc_aludec u_aludec (
        .aluop   (aluop),
        .funct   (funct),
        .alucont (alucont)
    );
endmodule
